tx_pam4_channel: RTL
====================

TX_PAM4_CHANNEL -- requirements
Module: tx_pam4_channel

Interface
REQ-001 SHALL have parameter PULSE_RESPONSE_LENGTH, default 5: number of pulse-response taps L.
REQ-002 SHALL have parameter SIGNAL_RESOLUTION, default 8: signed output sample and tap width W.
REQ-003 SHALL have parameter SYMBOL_SEPERATION, default 56: PAM4 level spacing S.
REQ-004 SHALL have parameter TAP_FRAC_BITS, default 6: tap fractional bits F.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have sym_in, input, 2: PAM4 symbol index.
REQ-008 SHALL have sym_valid / sym_ready, in/out, 1/1: symbol handshake; transfer when both are high.
REQ-009 SHALL have sym_last, input, 1: marks the final symbol of a burst; sampled on transfer.
REQ-010 SHALL have coef_wr_en, coef_addr, coef_data, inputs, 1 / clog2(L) / W: tap write port.
REQ-011 SHALL have signal_out, output, W signed: channel-distorted sample.
REQ-012 SHALL have signal_out_valid, output, 1: one-cycle strobe per sample, with no backpressure.
REQ-013 SHALL have busy, output, 1: high when state is not IDLE.
REQ-014 SHALL have sat_flag, output, 1: sticky saturation indicator.

Function
REQ-015 SHALL map symbols to levels: 0 -> +S/2, 1 -> -S/2, 2 -> +3S/2, 3 -> -3S/2, for pairing with the PAM4 DFE decision ordering.
REQ-016 SHALL keep an L-entry level history x[0..L-1], where x[0] is the newest level.
REQ-017 SHALL compute y = (sum k=0..L-1 of h[k]*x[k]) >>> F, with floor rounding.
- Accumulator width: 2W + clog2(L) + 2 bits.
REQ-018 SHALL saturate y to [-2^(W-1), 2^(W-1)-1] and set sat_flag whenever a clamp occurs.
REQ-019 SHALL use a 2-stage pipeline: signal_out_valid is asserted exactly 2 cycles after each history shift.
REQ-020 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-021 IDLE: sym_ready=1; a transfer SHALL go to RUN, or to FLUSH if sym_last=1.
REQ-022 RUN: sym_ready=1; a transfer with sym_last=1 SHALL go to FLUSH; cycles without a transfer SHALL not shift history and SHALL not produce output.
REQ-023 FLUSH: sym_ready=0; SHALL shift in a level of 0 once per cycle for L-1 cycles, then go to IDLE and clear the history to 0.
REQ-024 SHALL write coefficients only in IDLE with no transfer in the same cycle; writes in any other case SHALL be ignored; coef_addr >= L SHALL be ignored.
REQ-025 SHALL make a coefficient write affect only samples whose history shift occurs after the write cycle.
REQ-026 SHALL drain in-flight pipeline samples after an IDLE return even though busy=0.

Reset
REQ-027 On rstn low SHALL immediately clear: state=IDLE, history=0, pipeline=0, signal_out=0, signal_out_valid=0, sat_flag=0, busy=0.
REQ-028 SHALL reset taps to h[0]=2^F and h[k>0]=0 (identity channel).
REQ-029 Reset mid-burst or mid-FLUSH SHALL abort without emitting any further output.

Structure
REQ-030 SHALL place the FSM state enum, the PAM4 level-map function and default parameter constants in a shared package serdes_pkg, which the DFE also uses.
REQ-031 SHALL use one sub-module, tx_fir_mac: the pipelined multiply-accumulate with saturation.

Verification
REQ-032 Identity taps; symbols 0,1,2,3 back-to-back with sym_last on the last -> outputs 28,-28,84,-84, each 2 cycles after its transfer, followed by 4 flush zeros.
REQ-033 Taps [64,32,0,0,0]; symbols 2,2 with last -> outputs 84,126,42,0,0,0; sat_flag=0.
REQ-034 Taps [64,32,16,8,4]; single symbol 0 with last -> outputs 28,14,7,3,1; busy falls after 4 flush cycles, and sym_ready rises with it.
REQ-035 h[0]=127; symbol 2 -> output 127, sat_flag=1 and remaining set until reset.
REQ-036 Coefficient write during RUN is ignored, and outputs are unchanged; rstn pulse during FLUSH -> no further signal_out_valid, and all outputs return to reset values.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared SerDes definitions: channel FSM states, PAM4 level mapping and default parameters.
package serdes_pkg;

  localparam int unsigned DEF_PULSE_RESPONSE_LENGTH = 5;
  localparam int unsigned DEF_SIGNAL_RESOLUTION     = 8;
  localparam int unsigned DEF_SYMBOL_SEPERATION     = 56;
  localparam int unsigned DEF_TAP_FRAC_BITS         = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Symbol ordering matches the DFE slicer: inner levels first, outer levels last.
  function automatic int pam4_level(input logic [1:0] sym, input int sep);
    int lvl;
    case (sym)
      2'd0:    lvl = sep / 2;
      2'd1:    lvl = -(sep / 2);
      2'd2:    lvl = (3 * sep) / 2;
      default: lvl = -((3 * sep) / 2);
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tx_fir_mac.sv
// Two-stage FIR multiply-accumulate: stage 1 sums tap products, stage 2 scales and saturates.
module tx_fir_mac #(
  parameter int unsigned L   = 5,
  parameter int unsigned W   = 8,
  parameter int unsigned F   = 6,
  parameter int unsigned LVW = 10,
  parameter int unsigned AW  = 21
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid_i,
  input  logic [L-1:0][LVW-1:0] x_i,
  input  logic [L-1:0][W-1:0]   h_i,
  output logic signed [W-1:0]   y_o,
  output logic                  y_valid_o,
  output logic                  sat_flag_o
);

  localparam logic signed [AW-1:0] Y_MAX = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

  logic signed [AW-1:0] sum_c;
  logic signed [AW-1:0] shifted_c;
  logic signed [W-1:0]  y_c;
  logic                 clamp_c;

  logic signed [AW-1:0] acc_q;
  logic                 v1_q;
  logic signed [W-1:0]  y_q;
  logic                 v2_q;
  logic                 sat_q;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(L); k++) begin
      sum_c = sum_c + AW'($signed(h_i[k])) * AW'($signed(x_i[k]));
    end
  end

  // Arithmetic shift gives floor rounding for negative sums.
  always_comb begin
    shifted_c = acc_q >>> F;
    clamp_c   = 1'b0;
    y_c       = W'(shifted_c);
    if (shifted_c > Y_MAX) begin
      y_c     = W'(Y_MAX);
      clamp_c = 1'b1;
    end else if (shifted_c < Y_MIN) begin
      y_c     = W'(Y_MIN);
      clamp_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      v1_q  <= 1'b0;
      y_q   <= '0;
      v2_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) acc_q <= sum_c;
      v2_q <= v1_q;
      if (v1_q) begin
        y_q <= y_c;
        if (clamp_c) sat_q <= 1'b1;
      end
    end
  end

  assign y_o        = y_q;
  assign y_valid_o  = v2_q;
  assign sat_flag_o = sat_q;

endmodule

// File: rtl/tx_pam4_channel.sv
// PAM4 transmit channel model: symbol handshake, level history, tap storage and flush sequencing.
module tx_pam4_channel
  import serdes_pkg::*;
#(
  parameter int unsigned PULSE_RESPONSE_LENGTH = DEF_PULSE_RESPONSE_LENGTH,
  parameter int unsigned SIGNAL_RESOLUTION     = DEF_SIGNAL_RESOLUTION,
  parameter int unsigned SYMBOL_SEPERATION     = DEF_SYMBOL_SEPERATION,
  parameter int unsigned TAP_FRAC_BITS         = DEF_TAP_FRAC_BITS,
  localparam int unsigned ADDR_W = (PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [1:0]                          sym_in,
  input  logic                                sym_valid,
  output logic                                sym_ready,
  input  logic                                sym_last,
  input  logic                                coef_wr_en,
  input  logic [ADDR_W-1:0]                   coef_addr,
  input  logic [SIGNAL_RESOLUTION-1:0]        coef_data,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  output logic                                busy,
  output logic                                sat_flag
);

  localparam int unsigned L   = PULSE_RESPONSE_LENGTH;
  localparam int unsigned W   = SIGNAL_RESOLUTION;
  localparam int unsigned LVW = W + 2;
  localparam int unsigned AW  = 2 * W + $clog2(L) + 2;
  localparam int unsigned HW  = L * W;
  localparam logic [L-1:0][W-1:0] H_RST = HW'(1 << TAP_FRAC_BITS);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [L-1:0][LVW-1:0] x_q, x_d, x_shift_c;
  logic [L-1:0][W-1:0]   h_q, h_d;
  logic                  shift_q, shift_d;
  logic                  sym_ready_q, busy_q;
  logic                  xfer_c;
  logic [LVW-1:0]        lvl_c;

  assign xfer_c = sym_valid & sym_ready_q;
  assign lvl_c  = (state_q == ST_FLUSH) ? '0
                : LVW'(pam4_level(sym_in, int'(SYMBOL_SEPERATION)));

  always_comb begin
    x_shift_c    = '0;
    x_shift_c[0] = lvl_c;
    for (int k = 1; k < int'(L); k++) begin
      x_shift_c[k] = x_q[k-1];
    end
  end

  // Next-state: shifts happen on transfers and on every flush cycle; taps only change while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    h_d     = h_q;
    shift_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          shift_d = 1'b1;
          x_d     = x_shift_c;
          cnt_d   = '0;
          if (!sym_last)  state_d = ST_RUN;
          else if (L > 1) state_d = ST_FLUSH;
        end else begin
          x_d = '0;
          if (coef_wr_en && (32'(coef_addr) < L)) h_d[coef_addr] = coef_data;
        end
      end
      ST_RUN: begin
        if (xfer_c) begin
          shift_d = 1'b1;
          x_d     = x_shift_c;
          if (sym_last) begin
            cnt_d   = '0;
            state_d = (L > 1) ? ST_FLUSH : ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        shift_d = 1'b1;
        x_d     = x_shift_c;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (32'(cnt_q) + 32'd2 >= L) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      h_q         <= H_RST;
      shift_q     <= 1'b0;
      sym_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      h_q         <= h_d;
      shift_q     <= shift_d;
      sym_ready_q <= (state_d != ST_FLUSH);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sym_ready = sym_ready_q;
  assign busy      = busy_q;

  tx_fir_mac #(
    .L   (L),
    .W   (W),
    .F   (TAP_FRAC_BITS),
    .LVW (LVW),
    .AW  (AW)
  ) u_mac (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (shift_q),
    .x_i        (x_q),
    .h_i        (h_q),
    .y_o        (signal_out),
    .y_valid_o  (signal_out_valid),
    .sat_flag_o (sat_flag)
  );

endmodule
